// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Two-port round-robin arbiter and access sequencer for the    |
// |               main RAM. Port 0 is the CPU datapath and port 1 is the I/O / |
// |               loader DMA. Each access runs IDLE -> SETUP -> STROBE -> HOLD |
// |               -> ACK, so the RAM's edge-sensitive strobes are clean,       |
// |               non-overlapping pulses with stable address and data.         |
// | Ports       : clock, clear (async, active low)                             |
// |               pN_req/pN_we/pN_addr/pN_wdata : requester inputs, sampled    |
// |                                               in IDLE when granted         |
// |               pN_ack   : one-cycle completion pulse                        |
// |               pN_rdata : last read data for that port                      |
// |               mem_addr/mem_data_in/mem_write/mem_read : RAM drive          |
// |               mem_data_out : RAM read data                                 |
// |               busy/owner   : sequencer status                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STROBE_CYC = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    ACK    = 3'd4
  } state_t;

  // Strobe counter is loaded with the number of remaining STROBE cycles.
  localparam logic [2:0] c_strobe_last = 3'(STROBE_CYC - 1);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                last_served_q, last_served_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_read_q, mem_read_d;
  logic                busy_q, busy_d;
  logic                grant;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= 3'd0;
      last_served_q <= 1'b1;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      last_served_q <= last_served_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    last_served_d = last_served_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    grant         = 1'b0;

    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          // Contention goes to the port that was not served last.
          grant   = (p0_req && p1_req) ? ~last_served_q : p1_req;
          owner_d = grant;
          we_d    = grant ? p1_we    : p0_we;
          addr_d  = grant ? p1_addr  : p0_addr;
          wdata_d = grant ? p1_wdata : p0_wdata;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = c_strobe_last;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == 3'd0) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      HOLD: begin
        // RAM output is settled after the read strobe; capture it on exit.
        if (!we_q) begin
          if (owner_q) begin
            rdata1_d = mem_data_out;
          end else begin
            rdata0_d = mem_data_out;
          end
        end
        state_d = ACK;
      end
      ACK: begin
        last_served_d = owner_q;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so every pulse is glitch-free
  // and aligns exactly with the state it belongs to.
  always_comb begin
    mem_write_d = (state_d == STROBE) && we_d;
    mem_read_d  = (state_d == STROBE) && !we_d;
    ack0_d      = (state_d == ACK) && !owner_d;
    ack1_d      = (state_d == ACK) && owner_d;
    busy_d      = (state_d != IDLE);
  end

  assign p0_ack      = ack0_q;
  assign p1_ack      = ack1_q;
  assign p0_rdata    = rdata0_q;
  assign p1_rdata    = rdata1_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign mem_write   = mem_write_q;
  assign mem_read    = mem_read_q;
  assign busy        = busy_q;
  assign owner       = owner_q;

endmodule
`default_nettype wire
